// File: rtl/shift8_ctrl_if.sv
// Command/result bundle for shift8_ctrl: the master issues start/d_in/op/amt,
// the slave returns q/busy/done.
interface shift8_ctrl_if;
  logic       start;
  logic [7:0] d_in;
  logic [1:0] op;
  logic [2:0] amt;
  logic [7:0] q;
  logic       busy;
  logic       done;

  modport master (output start, d_in, op, amt, input  q, busy, done);
  modport slave  (input  start, d_in, op, amt, output q, busy, done);
endinterface

// File: rtl/shift8_ctrl.sv
// Sequential 8-bit shifter: one bit per cycle for amt cycles, then a one-cycle done pulse.
// start is only honoured in IDLE; anything arriving while busy or done is dropped.
module shift8_ctrl (
  input  logic         clk,
  input  logic         reset,
  shift8_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SEL_HOLD, SEL_LEFT, SEL_RIGHT, SEL_LOAD} sel_t;

  state_t     state_q;
  logic [7:0] q_q;
  logic [7:0] q_d;
  logic [2:0] cnt_q;
  logic [1:0] op_q;
  logic       busy_q;
  logic       done_q;

  sel_t       sel;
  logic [7:0] left_src;
  logic [7:0] right_src;

  always_comb begin
    sel = SEL_HOLD;
    if (state_q == IDLE && bus.start) begin
      sel = SEL_LOAD;
    end else if (state_q == SHIFT) begin
      sel = (op_q == 2'b01) ? SEL_LEFT : SEL_RIGHT;
    end
  end

  // Neighbour taps per bit; the top bit of the right tap is the sign only for ASR.
  assign left_src  = {q_q[6:0], 1'b0};
  assign right_src = {(op_q == 2'b11) & q_q[7], q_q[7:1]};

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign q_d[i] = (sel == SEL_LOAD)  ? bus.d_in[i] :
                    (sel == SEL_LEFT)  ? left_src[i] :
                    (sel == SEL_RIGHT) ? right_src[i] :
                                         q_q[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= 8'h00;
      cnt_q   <= 3'd0;
      op_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      q_q <= q_d;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q  <= bus.op;
            cnt_q <= bus.amt;
            if (bus.amt == 3'd0 || bus.op == 2'b00) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end
          if (cnt_q <= 3'd1) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q    = q_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_shift8_ctrl.sv
// Directed bench for shift8_ctrl with a cycle-level reference model and literal result checks.
module tb_shift8_ctrl;
  logic clk;
  logic reset;
  shift8_ctrl_if bus();

  shift8_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] shiftfn(input logic [7:0] d, input logic [1:0] o, input int k);
    logic signed [7:0] s;
    s = d;
    case (o)
      2'b01:   return d << k;
      2'b10:   return d >> k;
      2'b11:   return 8'(s >>> k);
      default: return d;
    endcase
  endfunction

  // Reference model: phase 0 idle, 1 shifting, 2 done; q is the operand shifted k places.
  int         m_phase = 0;
  int         m_k     = 0;
  int         m_amt   = 0;
  logic [7:0] m_d     = 8'h00;
  logic [1:0] m_op    = 2'b00;
  logic [7:0] m_q     = 8'h00;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0;
      m_q     = 8'h00;
    end else if (m_phase == 0) begin
      if (bus.start) begin
        m_d     = bus.d_in;
        m_op    = bus.op;
        m_amt   = int'(bus.amt);
        m_k     = 0;
        m_q     = bus.d_in;
        m_phase = (bus.amt == 3'd0 || bus.op == 2'b00) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      m_k++;
      m_q = shiftfn(m_d, m_op, m_k);
      if (m_k >= m_amt) m_phase = 2;
    end else begin
      m_phase = 0;
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("model_q",    int'(bus.q),    int'(m_q));
      check("model_busy", int'(bus.busy), (m_phase == 1) ? 1 : 0);
      check("model_done", int'(bus.done), (m_phase == 2) ? 1 : 0);
    end
  end

  // Issue one command and wait for done; checks busy length, result and pulse width.
  task automatic run_cmd(input string name, input logic [7:0] d, input logic [1:0] o,
                         input logic [2:0] a, input logic [7:0] exp_q, input int exp_busy);
    int nbusy;
    bit seen;
    nbusy = 0;
    seen  = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.d_in = d; bus.op = o; bus.amt = a;
    @(negedge clk);
    bus.start = 1'b0; bus.d_in = 8'h00; bus.op = 2'b00; bus.amt = 3'd0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done) begin seen = 1'b1; break; end
      if (bus.busy) nbusy++;
      @(negedge clk);
    end
    check({name, "_done_seen"}, int'(seen), 1);
    check({name, "_busy_cycles"}, nbusy, exp_busy);
    check({name, "_q"}, int'(bus.q), int'(exp_q));
    @(negedge clk);
    check({name, "_done_width"}, int'(bus.done), 0);
    check({name, "_q_hold"}, int'(bus.q), int'(exp_q));
  endtask

  initial begin
    int nbusy;
    bit seen;
    reset = 1'b1;
    bus.start = 1'b0; bus.d_in = 8'h00; bus.op = 2'b00; bus.amt = 3'd0;
    #1;
    check("reset_q",    int'(bus.q),    0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    @(negedge clk); @(negedge clk);
    reset  = 1'b0;
    cmp_en = 1'b1;

    run_cmd("lsl3",  8'hB1, 2'b01, 3'd3, 8'h88, 3);
    run_cmd("lsr3",  8'hB1, 2'b10, 3'd3, 8'h16, 3);
    run_cmd("asr3",  8'hB1, 2'b11, 3'd3, 8'hF6, 3);
    run_cmd("amt0",  8'h5A, 2'b01, 3'd0, 8'h5A, 0);
    run_cmd("nop5",  8'h5A, 2'b00, 3'd5, 8'h5A, 0);
    run_cmd("lsl7",  8'hFF, 2'b01, 3'd7, 8'h80, 7);
    run_cmd("asr7",  8'h80, 2'b11, 3'd7, 8'hFF, 7);
    run_cmd("lsr1",  8'h01, 2'b10, 3'd1, 8'h00, 1);

    // Second start plus operand changes while shifting must not disturb the first command.
    @(negedge clk);
    bus.start = 1'b1; bus.d_in = 8'hB1; bus.op = 2'b01; bus.amt = 3'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.d_in = 8'h0F; bus.op = 2'b10; bus.amt = 3'd1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("busy_start_done", int'(seen), 1);
    check("busy_start_q",    int'(bus.q), 8'h88);
    @(negedge clk);
    check("busy_start_not_queued", int'(bus.done | bus.busy), 0);
    bus.d_in = 8'h00; bus.op = 2'b00; bus.amt = 3'd0;
    @(negedge clk);

    // Reset between edges during SHIFT: outputs clear immediately, no done later.
    bus.start = 1'b1; bus.d_in = 8'hFF; bus.op = 2'b01; bus.amt = 3'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", int'(bus.busy), 1);
    #2 reset = 1'b1;
    #1;
    check("midreset_q",    int'(bus.q),    0);
    check("midreset_busy", int'(bus.busy), 0);
    check("midreset_done", int'(bus.done), 0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    nbusy = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      if (bus.busy) nbusy++;
    end
    check("post_reset_no_done", int'(seen), 0);
    check("post_reset_no_busy", nbusy, 0);

    run_cmd("after_reset", 8'hB1, 2'b11, 3'd2, 8'hEC, 2);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shift8_ctrl.md
SHIFT8_CTRL -- requirements
Module: shift8_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: command request, sampled on the clk rising edge.
REQ-004 The block SHALL have the port d_in, input, 8 bits: operand to be shifted, captured with the command.
REQ-005 The block SHALL have the port op, input, 2 bits: 00 pass/NOP, 01 logical shift left (LSL), 10 logical shift right (LSR), 11 arithmetic shift right (ASR).
REQ-006 The block SHALL have the port amt, input, 3 bits: shift amount 0..7.
REQ-007 The block SHALL have the port q, output, 8 bits: registered working/result value.
REQ-008 The block SHALL have the port busy, output, 1 bit: high while a command is in progress.
REQ-009 The block SHALL have the port done, output, 1 bit: one-cycle completion pulse; q is valid while done is high.

Function
REQ-010 The block SHALL implement an FSM with three states: IDLE, SHIFT and DONE.
REQ-011 In IDLE, start=1 at a rising edge (the accept edge, E0) SHALL load q<=d_in, latch op, and load a 3-bit counter with cnt<=amt.
REQ-012 At E0, the next state SHALL be DONE if amt==0 or op==00, otherwise SHIFT.
REQ-013 In SHIFT, each rising edge SHALL shift q by exactly one bit per the latched op.
REQ-014 LSL SHALL produce q<={q[6:0],1'b0}.
REQ-015 LSR SHALL produce q<={1'b0,q[7:1]}.
REQ-016 ASR SHALL produce q<={q[7],q[7:1]}.
REQ-017 Each SHIFT edge SHALL decrement cnt by 1.
REQ-018 On the SHIFT edge where cnt==1, cnt SHALL go to 0 and the next state SHALL be DONE; cnt SHALL never wrap below 0.
REQ-019 The result SHALL be visible with done=1 in the cycle following edge E(amt), i.e. amt+1 cycles after the accept cycle; for amt==0 or op==00 this is the cycle after E0.
REQ-020 DONE SHALL last exactly one cycle and then return unconditionally to IDLE.
REQ-021 busy SHALL be 1 exactly when the state is SHIFT; done SHALL be 1 exactly when the state is DONE; busy and done SHALL never both be 1.
REQ-022 start SHALL be accepted only in IDLE.
REQ-023 start in SHIFT or DONE SHALL be ignored and not queued.
REQ-024 Changes to d_in, op or amt after E0 SHALL NOT affect the command in progress.
REQ-025 q SHALL hold its value in IDLE and DONE until the next accepted start.
REQ-026 The datapath SHALL be a per-bit 4:1 selection (hold, left neighbour, right neighbour, load) controlled by the FSM; no multi-bit barrel path is permitted.

Reset
REQ-027 When reset=1, the block SHALL immediately, without waiting for clk, force state=IDLE, q=8'h00, cnt=0, busy=0 and done=0.
REQ-028 Reset asserted mid-SHIFT SHALL abort the command with no done pulse.
REQ-029 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.
REQ-030 All outputs SHALL be driven directly from registers.

Verification
REQ-031 The bench SHALL cover LSL: d_in=8'hB1, op=01, amt=3 -> busy high for 3 cycles, then done for 1 cycle with q=8'h88.
REQ-032 The bench SHALL cover LSR and ASR: d_in=8'hB1, amt=3, op=10 -> q=8'h16; op=11 -> q=8'hF6; done high one cycle each time.
REQ-033 The bench SHALL cover zero amount and NOP: amt=0, d_in=8'h5A -> done in the cycle after E0 with q=8'h5A and busy never high; the same result for op=00, amt=5.
REQ-034 The bench SHALL cover a full-range shift: d_in=8'hFF, op=01, amt=7 -> q=8'h80 after 7 busy cycles; op=11, d_in=8'h80, amt=7 -> q=8'hFF.
REQ-035 The bench SHALL cover start while busy: a second start with new d_in during SHIFT -> ignored, and the first result completes unchanged.
REQ-036 The bench SHALL cover reset mid-operation: assert reset between clock edges during SHIFT -> q=8'h00, busy=0 and done=0 immediately, with no done pulse afterwards.
